// File: rtl/mips32_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, with data priority
// and a data-streak limit. Define ARB_STATS_EN to add saturating grant/conflict counters.
module mips32_mem_arbiter #(
  parameter int AW          = 10,
  parameter int DW          = 32,
  parameter int MEM_LAT     = 1,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_i_grants,
  output logic [15:0]   stat_d_grants,
  output logic [15:0]   stat_conflicts
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  state_t        state_q, state_d;
  logic [3:0]    lat_cnt_q, lat_cnt_d;
  logic [3:0]    streak_q, streak_d;
  logic          gnt_is_d_q, gnt_is_d_d;
  logic          is_store_q, is_store_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          gnt_i, gnt_d, idle;

  // Fetch wins only when data is absent or the data streak has hit its limit.
  assign idle  = (state_q == S_IDLE);
  assign gnt_i = idle && i_req && (!d_req || (streak_q == STREAK_MAX));
  assign gnt_d = idle && d_req && !gnt_i;

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    streak_d   = streak_q;
    gnt_is_d_d = gnt_is_d_q;
    is_store_d = is_store_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    m_en_d     = 1'b0;
    m_we_d     = 1'b0;
    busy_d     = busy_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_i || gnt_d) begin
          state_d    = S_ISSUE;
          m_en_d     = 1'b1;
          busy_d     = 1'b1;
          gnt_is_d_d = gnt_d;
          is_store_d = gnt_d && d_we;
          m_we_d     = gnt_d && d_we;
          m_addr_d   = gnt_d ? d_addr : i_addr;
          m_wdata_d  = gnt_d ? d_wdata : '0;
        end
        if (gnt_i) begin
          streak_d = 4'd0;
        end else if (gnt_d && i_req) begin
          streak_d = streak_q + 4'd1;
        end
      end
      S_ISSUE: begin
        state_d   = S_WAIT;
        lat_cnt_d = LAT_LAST;
      end
      S_WAIT: begin
        // Read data is valid in the final WAIT cycle; capture it with the ack.
        if (lat_cnt_q == 4'd0) begin
          state_d = S_RESP;
          if (gnt_is_d_q) begin
            d_ack_d = 1'b1;
            if (!is_store_q) d_rdata_d = m_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= 4'd0;
      streak_q   <= 4'd0;
      gnt_is_d_q <= 1'b0;
      is_store_q <= 1'b0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      busy_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      streak_q   <= streak_d;
      gnt_is_d_q <= gnt_is_d_d;
      is_store_q <= is_store_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      busy_q     <= busy_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign i_ack   = i_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_rdata = d_rdata_q;
  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = busy_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_i_q, stat_i_d;
  logic [15:0] stat_d_q, stat_d_d;
  logic [15:0] stat_c_q, stat_c_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stat_i_d = gnt_i ? sat_inc(stat_i_q) : stat_i_q;
    stat_d_d = gnt_d ? sat_inc(stat_d_q) : stat_d_q;
    stat_c_d = (idle && i_req && d_req) ? sat_inc(stat_c_q) : stat_c_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_i_q <= 16'd0;
      stat_d_q <= 16'd0;
      stat_c_q <= 16'd0;
    end else begin
      stat_i_q <= stat_i_d;
      stat_d_q <= stat_d_d;
      stat_c_q <= stat_c_d;
    end
  end

  assign stat_i_grants  = stat_i_q;
  assign stat_d_grants  = stat_d_q;
  assign stat_conflicts = stat_c_q;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mips32_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_req, d_req, d_we, i_ack, d_ack, m_en, m_we, busy;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, i_rdata, d_rdata, m_wdata, m_rdata;

  logic          i_req3, d_req3, d_we3, i_ack3, d_ack3, m_en3, m_we3, busy3;
  logic [AW-1:0] i_addr3, d_addr3, m_addr3;
  logic [DW-1:0] d_wdata3, i_rdata3, d_rdata3, m_wdata3, m_rdata3;

`ifdef ARB_STATS_EN
  logic [15:0] stat_i_grants, stat_d_grants, stat_conflicts;
  logic [15:0] stat_i_grants3, stat_d_grants3, stat_conflicts3;
`endif

  int total = 0;
  int bad   = 0;

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .MAX_DSTREAK(4)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
`ifdef ARB_STATS_EN
    , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .MAX_DSTREAK(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3),
    .busy(busy3)
`ifdef ARB_STATS_EN
    , .stat_i_grants(stat_i_grants3), .stat_d_grants(stat_d_grants3),
    .stat_conflicts(stat_conflicts3)
`endif
  );

  // Latency-1 memory with a backdoor preload port; non-read cycles return a marker value.
  logic [DW-1:0] mem [0:1023];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (m_en && m_we) mem[m_addr] <= m_wdata;
    m_rdata <= (m_en && !m_we) ? mem[m_addr] : 32'hDEAD_BEEF;
  end

  // Latency-3 memory: contents are an address-derived pattern.
  logic [DW-1:0] p0, p1;
  always @(posedge clk) begin
    p0       <= m_en3 ? {22'h3C0DE, m_addr3} : 32'hBAD0_BAD0;
    p1       <= p0;
    m_rdata3 <= p1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req3 = 0; i_addr3 = '0; d_req3 = 0; d_we3 = 0; d_addr3 = '0; d_wdata3 = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    i_req = 1; d_req = 1;
    tick();
    do_reset();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if ({i_ack, d_ack, m_en, m_we} !== 4'b0) begin
      bad++; $display("FAIL reset_pulses: got %b want 0000", {i_ack, d_ack, m_en, m_we}); end
    total++; if (m_addr !== '0 || m_wdata !== '0) begin
      bad++; $display("FAIL reset_mbus: got %h/%h want 0/0", m_addr, m_wdata); end
    total++; if (i_rdata !== '0 || d_rdata !== '0) begin
      bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", i_rdata, d_rdata); end
    total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL reset_busy3: got %b want 0", busy3); end
  endtask

  task automatic test_single_fetch();
    preload(10'd5, 32'hA5A5_0001);
    do_reset();
    i_req = 1; i_addr = 10'd5;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fetch_busy_c0: got %b want 0", busy); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) i_req = 0;
      @(negedge clk);
      total++; if (m_en !== (c == 1)) begin
        bad++; $display("FAIL fetch_m_en c%0d: got %b want %b", c, m_en, (c == 1)); end
      total++; if (i_ack !== (c == 3)) begin
        bad++; $display("FAIL fetch_i_ack c%0d: got %b want %b", c, i_ack, (c == 3)); end
      total++; if (busy !== (c != 4)) begin
        bad++; $display("FAIL fetch_busy c%0d: got %b want %b", c, busy, (c != 4)); end
      if (c == 1) begin
        total++; if (m_addr !== 10'd5 || m_we !== 1'b0) begin
          bad++; $display("FAIL fetch_issue: got addr=%0d we=%b want 5/0", m_addr, m_we); end
      end
      if (c == 3) begin
        total++; if (i_rdata !== 32'hA5A5_0001) begin
          bad++; $display("FAIL fetch_rdata: got %h want a5a50001", i_rdata); end
      end
    end
  endtask

  task automatic test_store_load();
    do_reset();
    d_req = 1; d_we = 1; d_addr = 10'd9; d_wdata = 32'h1234;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 4) d_req = 0;
      if (c == 5) begin d_req = 1; d_we = 0; d_wdata = 32'hFFFF_FFFF; end
      if (c == 9) d_req = 0;
      @(negedge clk);
      total++; if (d_ack !== (c == 3 || c == 8) || i_ack !== 1'b0) begin
        bad++; $display("FAIL st_ld_ack c%0d: got d=%b i=%b want d=%b i=0", c, d_ack, i_ack,
                        (c == 3 || c == 8)); end
      if (c == 1) begin
        total++; if ({m_en, m_we} !== 2'b11 || m_addr !== 10'd9 || m_wdata !== 32'h1234) begin
          bad++; $display("FAIL store_issue: got en=%b we=%b a=%0d wd=%h want 1 1 9 1234",
                          m_en, m_we, m_addr, m_wdata); end
      end
      if (c == 3) begin
        total++; if (d_rdata !== 32'h0) begin
          bad++; $display("FAIL store_rdata: got %h want 0", d_rdata); end
      end
      if (c == 4) begin
        total++; if (mem[9] !== 32'h1234) begin
          bad++; $display("FAIL store_mem: got %h want 1234", mem[9]); end
      end
      if (c == 6) begin
        total++; if ({m_en, m_we} !== 2'b10) begin
          bad++; $display("FAIL load_issue: got en=%b we=%b want 1 0", m_en, m_we); end
      end
      if (c == 8) begin
        total++; if (d_rdata !== 32'h1234) begin
          bad++; $display("FAIL load_rdata: got %h want 1234", d_rdata); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] order;
    int cyc [0:9];
    int n;
    logic overlap;
    order = '0; n = 0; overlap = 1'b0;
    do_reset();
    i_req = 1; i_addr = 10'd5; d_req = 1; d_we = 0; d_addr = 10'd9;
    for (int c = 0; c < 60 && n < 10; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (i_ack && d_ack) overlap = 1'b1;
      if (i_ack || d_ack) begin
        order[n] = d_ack;
        cyc[n] = c;
        n++;
      end
    end
    tick();
    i_req = 0; d_req = 0;
    total++; if (n != 10) begin bad++; $display("FAIL b2b_count: got %0d acks want 10", n); end
    total++; if (order !== 10'b0111101111) begin
      bad++; $display("FAIL b2b_order: got %b want 0111101111 (bit0 first, 1=D)", order); end
    total++; if (overlap !== 1'b0) begin bad++; $display("FAIL b2b_overlap: got 1 want 0"); end
    total++; if (n == 10 && (cyc[0] != 3 || cyc[9] != 39)) begin
      bad++; $display("FAIL b2b_timing: got first=%0d last=%0d want 3/39", cyc[0], cyc[9]); end
    total++; if (i_rdata !== 32'hA5A5_0001 || d_rdata !== 32'h1234) begin
      bad++; $display("FAIL b2b_data: got %h/%h want a5a50001/1234", i_rdata, d_rdata); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1; d_we = 0; d_addr = 10'd9;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_wait: got %b want 1", busy); end
    for (int c = 3; c <= 8; c++) begin
      tick();
      if (c == 3) begin rst = 1'b0; d_req = 0; end
      if (c == 4) begin i_req = 1; i_addr = 10'd5; end
      if (c == 8) i_req = 0;
      @(negedge clk);
      total++; if (d_ack !== 1'b0 || i_ack !== (c == 7)) begin
        bad++; $display("FAIL mid_ack c%0d: got d=%b i=%b want d=0 i=%b", c, d_ack, i_ack,
                        (c == 7)); end
      if (c == 3) begin
        total++; if (busy !== 1'b0 || d_rdata !== '0) begin
          bad++; $display("FAIL mid_after_rst: got busy=%b d_rdata=%h want 0/0", busy, d_rdata); end
      end
      if (c == 7) begin
        total++; if (i_rdata !== 32'hA5A5_0001) begin
          bad++; $display("FAIL mid_refetch: got %h want a5a50001", i_rdata); end
      end
    end
  endtask

  task automatic test_latency3();
    do_reset();
    d_req3 = 1; d_we3 = 0; d_addr3 = 10'd20;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c >= 2) d_addr3 = 10'd21;
      if (c == 6) d_req3 = 0;
      @(negedge clk);
      total++; if (d_ack3 !== (c == 5)) begin
        bad++; $display("FAIL lat3_ack c%0d: got %b want %b", c, d_ack3, (c == 5)); end
      if (c == 1) begin
        total++; if (m_en3 !== 1'b1 || m_addr3 !== 10'd20) begin
          bad++; $display("FAIL lat3_issue: got en=%b a=%0d want 1/20", m_en3, m_addr3); end
      end
      if (c == 5) begin
        total++; if (d_rdata3 !== {22'h3C0DE, 10'd20}) begin
          bad++; $display("FAIL lat3_rdata: got %h want %h", d_rdata3, {22'h3C0DE, 10'd20}); end
      end
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) tick();
      i_req = (c != 8); i_addr = 10'd5;
      d_req = (c <= 3) || (c >= 9 && c <= 12) || (c >= 17); d_we = 0; d_addr = 10'd9;
    end
    @(negedge clk);
    total++; if (stat_conflicts !== 16'd3) begin
      bad++; $display("FAIL stat_conflicts: got %0d want 3", stat_conflicts); end
    total++; if (stat_i_grants !== 16'd2) begin
      bad++; $display("FAIL stat_i_grants: got %0d want 2", stat_i_grants); end
    total++; if (stat_d_grants !== 16'd3) begin
      bad++; $display("FAIL stat_d_grants: got %0d want 3", stat_d_grants); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; i_req = 0; d_req = 0;
    @(negedge clk);
    total++; if ({stat_conflicts, stat_i_grants, stat_d_grants} !== 48'd0) begin
      bad++; $display("FAIL stat_clear: got %0d/%0d/%0d want 0/0/0",
                      stat_conflicts, stat_i_grants, stat_d_grants); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req3 = 0; i_addr3 = '0; d_req3 = 0; d_we3 = 0; d_addr3 = '0; d_wdata3 = '0;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_back_to_back();
    test_reset_mid();
    test_latency3();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
